// File: rtl/al_key_entry_pkg.sv
// Shared alarm-clock definitions: key-entry FSM encodings, BCD limits and the
// HHMM range-check helper.
package al_pkg;

  localparam int         BCD_DIGIT_W  = 4;
  localparam logic [7:0] MAX_HOUR_BCD = 8'h23;
  localparam logic [3:0] MAX_MIN_TENS = 4'd5;

  typedef enum logic [1:0] {
    AL_KEY_IDLE  = 2'd0,
    AL_KEY_ENTRY = 2'd1,
    AL_KEY_LOAD  = 2'd2
  } al_key_state_e;

  // Digits are BCD by construction, so only the clock-face limits need checking.
  function automatic logic bcd_time_ok(input logic [15:0] hhmm);
    logic ok_s;
    ok_s = (hhmm[15:8] <= MAX_HOUR_BCD) && (hhmm[7:4] <= MAX_MIN_TENS);
    if (hhmm[15:12] == 4'd2) begin
      ok_s = ok_s && (hhmm[11:8] <= 4'd3);
    end else begin
      ok_s = ok_s;
    end
    return ok_s;
  endfunction

endpackage

// File: rtl/al_key_entry_if.sv
// Keypad / time-load bus between the key-entry block (slave) and its driver
// (master: keypad scanner side, which also supplies the 256 Hz strobe).
interface al_key_if;
  import al_pkg::*;

  logic                   clk256;
  logic                   key_valid;
  logic [BCD_DIGIT_W-1:0] key_code;
  logic                   set_time_btn;
  logic                   clear_btn;
  logic [15:0]            key_buffer;
  logic [15:0]            time_in;
  logic                   load_new_time;
  logic                   entry_active;
  logic                   entry_error;

  modport master (
    output clk256, key_valid, key_code, set_time_btn, clear_btn,
    input  key_buffer, time_in, load_new_time, entry_active, entry_error
  );

  modport slave (
    input  clk256, key_valid, key_code, set_time_btn, clear_btn,
    output key_buffer, time_in, load_new_time, entry_active, entry_error
  );

endinterface

// File: rtl/al_key_entry_edge_detect.sv
// Registered rising-edge detector; turns a slow level (e.g. clk256) into a
// one-cycle tick in the clk domain.
module al_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q_r;

  // previous-cycle copy of the input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q_r <= 1'b0;
    end else begin
      sig_q_r <= sig;
    end
  end

  assign rise = sig & ~sig_q_r;

endmodule

// File: rtl/al_key_entry.sv
// Keypad HHMM entry with commit strobe and inactivity timeout.
// Build option AL_KEY_RANGE_CHECK_EN: reject commits that are not a valid 24h time.
module al_key_entry
  import al_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 2560,
  parameter int TICK_CNT_W    = 12
) (
  input logic     clk,
  input logic     reset,
  al_key_if.slave bus
);

  localparam logic [TICK_CNT_W-1:0] TMO_LIM  = TICK_CNT_W'(TIMEOUT_TICKS);
  localparam logic [TICK_CNT_W-1:0] TMO_ONE  = TICK_CNT_W'(1);
  localparam logic [2:0]            FULL_CNT = 3'd4;

  al_key_state_e         state_r, state_n_s;
  logic [2:0]            count_r, count_n_s;
  logic [TICK_CNT_W-1:0] tmo_cnt_r, tmo_n_s, tmo_inc_s;
  logic [15:0]           key_buffer_r, buf_n_s;
  logic [15:0]           time_in_r, time_n_s;
  logic                  error_r, err_n_s;
  logic                  load_r, active_r;
  logic                  tick_s, digit_s, range_ok_s;

  al_edge_detect u_tick (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.clk256),
    .rise  (tick_s)
  );

  assign digit_s = bus.key_valid && (bus.key_code <= 4'd9);

`ifdef AL_KEY_RANGE_CHECK_EN
  assign range_ok_s = bcd_time_ok(key_buffer_r);
`else
  assign range_ok_s = 1'b1;
`endif

  // next-state and datapath decode; priority clear > set > digit > timeout
  always_comb begin
    state_n_s = state_r;
    count_n_s = count_r;
    buf_n_s   = key_buffer_r;
    time_n_s  = time_in_r;
    err_n_s   = error_r;
    tmo_n_s   = {TICK_CNT_W{1'b0}};
    if (tick_s && (tmo_cnt_r < TMO_LIM)) begin
      tmo_inc_s = tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_inc_s = tmo_cnt_r;
    end

    case (state_r)
      AL_KEY_IDLE: begin
        if (bus.clear_btn) begin
          buf_n_s   = 16'h0000;
          count_n_s = 3'd0;
          err_n_s   = 1'b0;
        end else if (bus.set_time_btn) begin
          state_n_s = AL_KEY_IDLE;
        end else if (digit_s) begin
          state_n_s = AL_KEY_ENTRY;
          buf_n_s   = {12'h000, bus.key_code};
          count_n_s = 3'd1;
          err_n_s   = 1'b0;
        end else begin
          state_n_s = AL_KEY_IDLE;
        end
      end

      AL_KEY_ENTRY: begin
        tmo_n_s = tmo_inc_s;
        if (bus.clear_btn) begin
          state_n_s = AL_KEY_IDLE;
          buf_n_s   = 16'h0000;
          count_n_s = 3'd0;
          err_n_s   = 1'b0;
          tmo_n_s   = {TICK_CNT_W{1'b0}};
        end else if (bus.set_time_btn) begin
          if ((count_r == FULL_CNT) && range_ok_s) begin
            state_n_s = AL_KEY_LOAD;
            time_n_s  = key_buffer_r;
            tmo_n_s   = {TICK_CNT_W{1'b0}};
          end else begin
            err_n_s = 1'b1;
          end
        end else if (digit_s && (count_r < FULL_CNT)) begin
          buf_n_s   = {key_buffer_r[11:0], bus.key_code};
          count_n_s = count_r + 3'd1;
          err_n_s   = 1'b0;
          tmo_n_s   = {TICK_CNT_W{1'b0}};
        end else if (tmo_inc_s >= TMO_LIM) begin
          // error flag survives the timeout so the user still sees the rejection
          state_n_s = AL_KEY_IDLE;
          buf_n_s   = 16'h0000;
          count_n_s = 3'd0;
          tmo_n_s   = {TICK_CNT_W{1'b0}};
        end else begin
          state_n_s = AL_KEY_ENTRY;
        end
      end

      AL_KEY_LOAD: begin
        state_n_s = AL_KEY_IDLE;
        buf_n_s   = 16'h0000;
        count_n_s = 3'd0;
      end

      default: begin
        state_n_s = AL_KEY_IDLE;
        buf_n_s   = 16'h0000;
        count_n_s = 3'd0;
      end
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= AL_KEY_IDLE;
      count_r      <= 3'd0;
      tmo_cnt_r    <= {TICK_CNT_W{1'b0}};
      key_buffer_r <= 16'h0000;
      time_in_r    <= 16'h0000;
      error_r      <= 1'b0;
      load_r       <= 1'b0;
      active_r     <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      count_r      <= count_n_s;
      tmo_cnt_r    <= tmo_n_s;
      key_buffer_r <= buf_n_s;
      time_in_r    <= time_n_s;
      error_r      <= err_n_s;
      load_r       <= (state_n_s == AL_KEY_LOAD);
      active_r     <= (state_n_s == AL_KEY_ENTRY);
    end
  end

  assign bus.key_buffer    = key_buffer_r;
  assign bus.time_in       = time_in_r;
  assign bus.load_new_time = load_r;
  assign bus.entry_active  = active_r;
  assign bus.entry_error   = error_r;

endmodule

// File: tb/tb_al_key_entry.sv
// Directed bench for al_key_entry: commit strobes go through a scoreboard queue,
// state outputs are checked directly after each stimulus step.
module tb_al_key_entry;
  import al_pkg::*;

  typedef struct {
    logic [15:0] t;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;
  logic [15:0] last_time = 16'h0000;
  exp_t exp_q[$];

  al_key_if bus ();

  al_key_entry #(.TIMEOUT_TICKS(2560), .TICK_CNT_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    step();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic set_btn(input bit expect_load, input logic [15:0] t);
    exp_t e;
    if (expect_load) begin
      e.t  = t;
      e.at = cyc + 1;
      exp_q.push_back(e);
      last_time = t;
    end
    bus.set_time_btn = 1'b1;
    step();
    bus.set_time_btn = 1'b0;
  endtask

  task automatic tick();
    bus.clk256 = 1'b1;
    step();
    bus.clk256 = 1'b0;
    step();
  endtask

  initial begin
    reset            = 1'b1;
    bus.clk256       = 1'b0;
    bus.key_valid    = 1'b0;
    bus.key_code     = 4'd0;
    bus.set_time_btn = 1'b0;
    bus.clear_btn    = 1'b0;

    fork
      // stimulus and direct state checks
      begin
        step();
        chk("rst_key_buffer", {16'h0, bus.key_buffer}, 32'h0);
        chk("rst_time_in", {16'h0, bus.time_in}, 32'h0);
        chk("rst_load", {31'h0, bus.load_new_time}, 32'h0);
        chk("rst_active", {31'h0, bus.entry_active}, 32'h0);
        chk("rst_error", {31'h0, bus.entry_error}, 32'h0);
        step();
        reset = 1'b0;
        step();

        // basic entry and commit
        key(4'd1); chk("t1_buf1", {16'h0, bus.key_buffer}, 32'h0001);
        chk("t1_active", {31'h0, bus.entry_active}, 32'h1);
        key(4'd2); chk("t1_buf2", {16'h0, bus.key_buffer}, 32'h0012);
        key(4'd3); chk("t1_buf3", {16'h0, bus.key_buffer}, 32'h0123);
        key(4'd6); chk("t1_buf4", {16'h0, bus.key_buffer}, 32'h1236);
        set_btn(1'b1, 16'h1236);
        chk("t1_load_hi", {31'h0, bus.load_new_time}, 32'h1);
        step();
        chk("t1_load_lo", {31'h0, bus.load_new_time}, 32'h0);
        chk("t1_buf_clr", {16'h0, bus.key_buffer}, 32'h0);
        chk("t1_idle", {31'h0, bus.entry_active}, 32'h0);

        // 25:00 entry
        key(4'd2); key(4'd5); key(4'd0); key(4'd0);
`ifdef AL_KEY_RANGE_CHECK_EN
        set_btn(1'b0, 16'h0000);
        chk("t2_noload", {31'h0, bus.load_new_time}, 32'h0);
        chk("t2_error", {31'h0, bus.entry_error}, 32'h1);
        chk("t2_buf", {16'h0, bus.key_buffer}, 32'h2500);
        bus.clear_btn = 1'b1; step(); bus.clear_btn = 1'b0;
        chk("t2_clear_err", {31'h0, bus.entry_error}, 32'h0);
`else
        set_btn(1'b1, 16'h2500);
        chk("t2_load", {31'h0, bus.load_new_time}, 32'h1);
        chk("t2_noerr", {31'h0, bus.entry_error}, 32'h0);
        step();
`endif

        // short entry rejected, error clears on next digit
        key(4'd1); key(4'd6);
        set_btn(1'b0, 16'h0000);
        chk("t3_error", {31'h0, bus.entry_error}, 32'h1);
        chk("t3_buf_kept", {16'h0, bus.key_buffer}, 32'h0016);
        chk("t3_active", {31'h0, bus.entry_active}, 32'h1);
        key(4'd3);
        chk("t3_err_clr", {31'h0, bus.entry_error}, 32'h0);
        key(4'd0);
        set_btn(1'b1, 16'h1630);
        step();

        // inactivity timeout
        key(4'd1);
        for (int i = 0; i < 2559; i++) tick();
        chk("t4_still_active", {31'h0, bus.entry_active}, 32'h1);
        tick();
        chk("t4_timeout", {31'h0, bus.entry_active}, 32'h0);
        chk("t4_buf_clr", {16'h0, bus.key_buffer}, 32'h0);
        set_btn(1'b0, 16'h0000);
        chk("t4_noload", {31'h0, bus.load_new_time}, 32'h0);

        // fifth digit and non-digit codes ignored; clear beats set
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        chk("t5_full", {16'h0, bus.key_buffer}, 32'h1234);
        key(4'd12);
        chk("t5_code12", {16'h0, bus.key_buffer}, 32'h1234);
        bus.clear_btn = 1'b1; bus.set_time_btn = 1'b1;
        step();
        bus.clear_btn = 1'b0; bus.set_time_btn = 1'b0;
        chk("t5_idle", {31'h0, bus.entry_active}, 32'h0);
        chk("t5_noload", {31'h0, bus.load_new_time}, 32'h0);
        chk("t5_buf_clr", {16'h0, bus.key_buffer}, 32'h0);
        chk("t5_time_kept", {16'h0, bus.time_in}, {16'h0, last_time});
        step();

        // reset during the LOAD cycle kills the strobe at once
        key(4'd0); key(4'd9); key(4'd4); key(4'd5);
        bus.set_time_btn = 1'b1; step(); bus.set_time_btn = 1'b0;
        chk("t6_load_hi", {31'h0, bus.load_new_time}, 32'h1);
        chk("t6_time", {16'h0, bus.time_in}, 32'h0945);
        reset = 1'b1;
        #1;
        chk("t6_load_rst", {31'h0, bus.load_new_time}, 32'h0);
        chk("t6_time_rst", {16'h0, bus.time_in}, 32'h0);
        chk("t6_active_rst", {31'h0, bus.entry_active}, 32'h0);
        step(); step();
        reset = 1'b0;
        step(); step();
        chk("pending_loads", exp_q.size(), 32'h0);
        done = 1'b1;
      end

      // monitor: every strobe must match the next queued commit
      begin
        exp_t e;
        while (!done) begin
          @(negedge clk);
          if (bus.load_new_time === 1'b1) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_load: time_in %h with no commit pending", bus.time_in);
            end else begin
              e = exp_q.pop_front();
              chk("load_time_in", {16'h0, bus.time_in}, {16'h0, e.t});
              chk("load_cycle", cyc, e.at);
            end
          end
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/al_key_entry.md
Name: al_key_entry

Overview:
- Keypad-side writer for the alarm-clock time-load interface; the counter's time_in / load_new_time pair is its output.
- Collects BCD digit key presses into an HHMM buffer and range-checks the result.
- On the set-time button, issues a one-cycle load_new_time strobe with the validated 16-bit BCD time.
- Abandons a partial entry after an inactivity timeout measured in clk256 ticks.

Parameters:
- TIMEOUT_TICKS, 2560, number of clk256 rising edges (10 s at 256 Hz) of inactivity before a partial entry is discarded.
- TICK_CNT_W, 12, width of the timeout counter; must hold TIMEOUT_TICKS.

Ports:
- clk  input  1  system clock (MCLK); all logic is on posedge clk.
- reset  input  1  asynchronous, active-high reset.
- clk256  input  1  256 Hz strobe from FREQ_DIV, sampled in the clk domain; a rising edge is one tick.
- key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
- key_code  input  4  0-9 are digits; 10-15 are ignored.
- set_time_btn  input  1  one-cycle request to commit the entry.
- clear_btn  input  1  one-cycle request to discard the entry.
- key_buffer  output  16  digits entered so far, for display; most recent digit in [3:0].
- time_in  output  16  BCD HHMM presented to the counter; holds the last committed value.
- load_new_time  output  1  one-cycle strobe; time_in is valid in the same cycle.
- entry_active  output  1  high while in ENTRY.
- entry_error  output  1  sticky flag: the last commit attempt was rejected.

Behaviour:
- Reset (async): all outputs 0, FSM in IDLE, digit count 0, timeout count 0, clk256 edge-detect flop 0.
- Tick detection: tick = clk256 & ~clk256_q, with clk256_q registered on clk.
- States:
  - IDLE: key_buffer = 0.
  - ENTRY: collecting digits.
  - LOAD: a single cycle in which load_new_time = 1.
- Input priority in IDLE/ENTRY, same cycle: clear_btn > set_time_btn > key_valid.
- Digit key (code 0-9) with key_valid:
  - IDLE -> ENTRY; key_buffer <= {12'h0, code}; count = 1.
  - ENTRY with count < 4: key_buffer <= {key_buffer[11:0], code}; count + 1.
  - ENTRY with count = 4: digit ignored.
  - Any accepted digit clears entry_error and resets the timeout counter.
- Codes 10-15: ignored entirely; no state change, no timeout reset.
- clear_btn: any state except LOAD -> IDLE; key_buffer, count and entry_error cleared.
- set_time_btn in ENTRY:
  - count = 4 and range check passes: time_in <= key_buffer, -> LOAD.
  - Otherwise: entry_error <= 1, stay in ENTRY with the buffer kept.
- set_time_btn in IDLE: no effect.
- LOAD: load_new_time = 1 for exactly this cycle, then -> IDLE with key_buffer and count cleared. All inputs are ignored during LOAD.
- Latency: load_new_time asserts on the first clk edge after the set_time_btn cycle.
- Timeout: counts ticks only in ENTRY. Reaching TIMEOUT_TICKS -> IDLE with buffer cleared; entry_error is preserved.
- Timeout counter saturates and never wraps.
- Range check: hour (bits [15:8]) <= 8'h23; minute tens (bits [7:4]) <= 5; hour ones <= 3 when hour tens = 2. BCD digits are already 0-9 by construction.
- time_in is updated only in the LOAD transition.
- Reset asserted mid-entry or in LOAD: immediate return to reset values, so no partial strobe.

Optional Feature:
- Macro: AL_KEY_RANGE_CHECK_EN.
- Defined: the range check above applies.
- Undefined: any 4-digit entry commits (e.g. 16'h9999 loads); entry_error is set only for count < 4.

Decomposition:
- Shared package al_pkg holds:
  - state encodings AL_KEY_IDLE / AL_KEY_ENTRY / AL_KEY_LOAD;
  - BCD_DIGIT_W = 4;
  - MAX_HOUR_BCD = 8'h23;
  - MAX_MIN_TENS = 4'd5.
- One sub-module: al_edge_detect, a registered rising-edge detector for clk256, reusable by other alarm blocks.

Test Plan:
- Release reset, keys 1,2,3,6, set_time_btn -> key_buffer steps 0001, 0012, 0123, 1236; next cycle load_new_time = 1 for 1 cycle with time_in = 16'h1236; then key_buffer = 0.
- Keys 2,5,0,0, set -> no load_new_time, entry_error = 1, key_buffer = 16'h2500 (range check on). Rebuild with macro off -> loads 16'h2500.
- Keys 1,6, set -> entry_error = 1. Then keys 3,0, set -> entry_error clears on key 3, then load with time_in = 16'h1630.
- Key 1, then 2560 clk256 edges with no keys -> entry_active falls, key_buffer = 0; a later set_time_btn produces no load.
- Keys 1,2,3,4 with clear_btn and set_time_btn in the same cycle -> clear wins: IDLE, no load, time_in unchanged.
- Reset asserted during the LOAD cycle -> load_new_time = 0 immediately, time_in = 0.
